// File: rtl/aes_pkg.sv
// Shared AES-128 constants, helpers and key-schedule state encoding.
// Imported by the key schedule and the round datapaths.
package aes_pkg;

   localparam int NR        = 10;
   localparam int NK        = 4;
   localparam int KEYW      = 128;
   localparam int RK_COUNT  = 11;
   localparam int IDXW      = 4;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1b;

   typedef logic [0:KEYW-1] key_t;
   typedef logic [0:31]     word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } state_e;

   // GF(2^8) multiply by x, reduced by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
   endfunction

   // Round constant for rounds 1..10; zero elsewhere.
   function automatic logic [7:0] rcon_of(input logic [3:0] i);
      logic [7:0] r;
      r = 8'h00;
      unique case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
// Ports: in_i (8-bit byte), out_o (substituted byte).
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Row-major table, entry 0 is leftmost.
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] base;

   assign base  = {in_i, 3'b000};
   assign out_o = SBOX[base +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per clock into an 11-entry
// register file, read by index with one cycle of latency.
// Ports: clk, reset (sync, active-high), start, key[0:127],
//        rk_idx, round_key[0:127], rk_valid, busy, ready.
module aes_key_schedule
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [0:KEYW-1] key,
   input  logic [IDXW-1:0] rk_idx,
   output logic [0:KEYW-1] round_key,
   output logic            rk_valid,
   output logic            busy,
   output logic            ready
);

   state_e          state_q, state_d;
   key_t            rk_q [RK_COUNT];
   key_t            w_q;
   logic [IDXW-1:0] cnt_q;
   logic [7:0]      rcon_q;
   key_t            rd_q;
   logic            valid_q;

   word_t w0, w1, w2, w3;
   word_t rot, sub, temp;
   word_t n0, n1, n2, n3;
   key_t  n_key;
   key_t  rd_d;
   logic  idx_ok;
   logic  ready_d;

   // ---------------- round function ----------------
   assign w0 = w_q[0:31];
   assign w1 = w_q[32:63];
   assign w2 = w_q[64:95];
   assign w3 = w_q[96:127];

   assign rot = {w3[8:31], w3[0:7]};

   for (genvar g = 0; g < NK; g++) begin : g_sub
      aes_sbox u_sbox (
         .in_i  (rot[8*g +: 8]),
         .out_o (sub[8*g +: 8])
      );
   end

   assign temp  = sub ^ {rcon_q, 24'h0};
   assign n0    = w0 ^ temp;
   assign n1    = w1 ^ n0;
   assign n2    = w2 ^ n1;
   assign n3    = w3 ^ n2;
   assign n_key = {n0, n1, n2, n3};

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = EXPAND;
         end
         EXPAND: begin
            // start restarts; otherwise leave after writing rk[10]
            if (start)                   state_d = EXPAND;
            else if (cnt_q == IDXW'(NR)) state_d = READY;
         end
         READY: begin
            if (start) state_d = EXPAND;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == EXPAND);
      ready = (state_q == READY);
   end

   // ---------------- key register file ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RK_COUNT; i++) rk_q[i] <= '0;
         w_q    <= '0;
         cnt_q  <= '0;
         rcon_q <= '0;
      end else if (start) begin
         rk_q[0] <= key;
         w_q     <= key;
         cnt_q   <= IDXW'(1);
         rcon_q  <= RCON_INIT;
      end else if (state_q == EXPAND) begin
         for (int i = 1; i < RK_COUNT; i++) begin
            if (cnt_q == IDXW'(i)) rk_q[i] <= n_key;
         end
         w_q    <= n_key;
         cnt_q  <= cnt_q + IDXW'(1);
         rcon_q <= xtime(rcon_q);
      end
   end

   // ---------------- read port ----------------
   assign idx_ok  = (rk_idx <= IDXW'(NR));
   assign ready_d = (state_d == READY);

   // Reads the pre-edge contents, so an entry written on this edge
   // returns its old value.
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < RK_COUNT; i++) begin
         if (rk_idx == IDXW'(i)) rd_d = rk_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         valid_q <= ready_d && idx_ok;
      end
   end

   assign round_key = rd_q;
   assign rk_valid  = valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 A.1 and
// zero-key vectors, restart, reset and read-port boundaries.
module tb_aes_key_schedule;

   logic           clk;
   logic           reset;
   logic           start;
   logic [0:127]   key;
   logic [3:0]     rk_idx;
   logic [0:127]   round_key;
   logic           rk_valid;
   logic           busy;
   logic           ready;

   int n_checks;
   int n_errors;

   logic [127:0] a1 [0:10];
   logic [127:0] zk1, zk10;

   aes_key_schedule dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .key       (key),
      .rk_idx    (rk_idx),
      .round_key (round_key),
      .rk_valid  (rk_valid),
      .busy      (busy),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one edge (E0).
   task automatic start_key(input logic [127:0] k);
      key   = k;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Counts edges after E0 until ready; expects exactly 10.
   task automatic run_to_ready(input string tag, input int done);
      int edges;
      edges = done;
      for (int i = 0; i < 30; i++) begin
         if (ready) break;
         check({tag, "_busy"}, 128'(busy), 128'd1);
         step();
         edges++;
      end
      check({tag, "_edges"}, 128'(edges), 128'd10);
      check({tag, "_busy_done"}, 128'(busy), 128'd0);
   endtask

   task automatic rd(input string tag, input logic [3:0] idx,
                     input logic [127:0] exp, input logic expv);
      rk_idx = idx;
      step();
      check({tag, "_key"}, round_key, exp);
      check({tag, "_vld"}, 128'(rk_valid), 128'(expv));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
      a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      zk1    = 128'h62636363626363636263636362636363;
      zk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

      reset  = 1'b1;
      start  = 1'b0;
      key    = '0;
      rk_idx = '0;
      step();
      step();
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_ready", 128'(ready), 128'd0);
      check("rst_rk", round_key, 128'd0);
      check("rst_vld", 128'(rk_valid), 128'd0);
      reset = 1'b0;

      // A.1 key with reads during expansion
      start_key(a1[0]);
      check("e0_busy", 128'(busy), 128'd1);
      check("e0_ready", 128'(ready), 128'd0);
      step();
      rd("exp_idx3", 4'd3, 128'd0, 1'b0);
      rd("exp_idx0", 4'd0, a1[0], 1'b0);
      run_to_ready("a1", 3);
      for (int i = 10; i >= 0; i--)
         rd($sformatf("a1_idx%0d", i), 4'(i), a1[i], 1'b1);
      rd("idx11", 4'd11, 128'd0, 1'b0);
      rd("idx15", 4'd15, 128'd0, 1'b0);

      // zero key
      start_key(128'd0);
      run_to_ready("zk", 0);
      rd("zk_idx1", 4'd1, zk1, 1'b1);
      rd("zk_idx10", 4'd10, zk10, 1'b1);
      rd("zk_idx0", 4'd0, 128'd0, 1'b1);

      // restart at E4
      start_key(128'd0);
      step();
      step();
      step();
      check("rs_ready_mid", 128'(ready), 128'd0);
      start_key(a1[0]);
      check("rs_ready_e0", 128'(ready), 128'd0);
      run_to_ready("rs", 0);
      for (int i = 0; i <= 10; i++)
         rd($sformatf("rs_idx%0d", i), 4'(i), a1[i], 1'b1);

      // reset at E5
      start_key(a1[0]);
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mr_busy", 128'(busy), 128'd0);
      check("mr_ready", 128'(ready), 128'd0);
      check("mr_rk", round_key, 128'd0);
      for (int i = 0; i <= 10; i++)
         rd($sformatf("mr_idx%0d", i), 4'(i), 128'd0, 1'b0);

      // reset wins over start
      reset = 1'b1;
      key   = a1[0];
      start = 1'b1;
      step();
      reset = 1'b0;
      start = 1'b0;
      check("rs_st_busy", 128'(busy), 128'd0);
      step();
      step();
      check("rs_st_busy2", 128'(busy), 128'd0);
      check("rs_st_ready", 128'(ready), 128'd0);
      rd("rs_st_idx0", 4'd0, 128'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
